pci_target_controller: RTL and testbench
========================================

// Module: pci_target_controller
// PURPOSE
//  PCI target (responder) for single and burst memory read/write transactions
//  issued by the initiator controller. Claims a transaction by address decode, asserts
//  devsel/trdy, and holds a small word-addressed local memory. It returns read data
//  on AD or stores write data under byte enables. Sits on the shared AD/C_BE/frame/irdy bus.
// PARAMETERS
//  DEV_ID       2'b01  device number, matched against AD[31:30] in the address phase
//  MEM_DEPTH    8      local memory words (32-bit), power of two, index = AD[4:2]
//  WAIT_STATES  0      idle cycles (0..3) before the first trdy assertion of a burst
// PORTS
//  clk     in     1   bus clock, all sampling on posedge
//  rst_n   in     1   asynchronous active-low reset
//  frame   in     1   active-low, from initiator
//  irdy    in     1   active-low initiator ready
//  C_BE    in     4   address phase: command; data phase: active-low byte enables
//  AD      inout  32  address in; write data in; read data out
//  devsel  out    1   active-low device select, tri-stated when not claimed
//  trdy    out    1   active-low target ready, tri-stated when not claimed
//  busy    out    1   active-high, 1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; devsel, trdy and AD = Z; busy=0; ptr=0; frame_q=1;
//   all memory words = 0. Reset mid-burst aborts immediately, with no further writes.
//  Address phase = posedge with frame==0 && frame_q==1 (frame_q is registered frame).
//  Hit = addr phase && AD[31:30]==DEV_ID && C_BE in {4'b0110 read, 4'b0111 write}.
//   Otherwise there is no claim, and outputs stay Z.
//  On hit: latch ptr=AD[4:2] and cmd. Set wcnt=WAIT_STATES.
//  FSM states: IDLE, TURN, WAIT, DATA, BACKOFF.
//   IDLE -> TURN  on a read hit. IDLE -> WAIT on a write hit.
//   TURN: exactly 1 cycle; devsel=0, trdy=1, AD=Z (bus turnaround). Then -> WAIT.
//   WAIT: devsel=0, trdy=1. Decrement wcnt each cycle; -> DATA when wcnt==0.
//    With WAIT_STATES=0, WAIT lasts 0 cycles: the FSM goes direct to DATA.
//   DATA: devsel=0, trdy=0. Read: AD driven = mem[ptr] combinationally.
//    Transfer = posedge with irdy==0 && trdy==0 in DATA.
//    On a write transfer, mem[ptr][8i+7:8i] <= AD[8i+7:8i] for each i with C_BE[i]==0.
//    Each transfer does ptr <= ptr+1 mod MEM_DEPTH (wraps 7 -> 0).
//    A transfer with frame==1 is the last data phase -> BACKOFF.
//    irdy==1 means no transfer: hold state, ptr and AD.
//   BACKOFF: 1 cycle; devsel=1, trdy=1 (driven high), AD=Z. Then -> IDLE (all Z).
//  Latency: write, first trdy=0 is WAIT_STATES+1 clocks after the address phase;
//   read, WAIT_STATES+2 clocks.
//  AD is driven only in DATA of a read. It is never driven in TURN, WAIT, BACKOFF or
//   IDLE, and never on writes.
//  A new address phase seen while not IDLE is ignored.
//  If frame rises with no transfer completed, the FSM stays in DATA until a transfer
//   with irdy==0.
//  Bytes whose enable is 1 in a write are left unchanged.
// TESTING
//  1 Write hit, DEV_ID=1: AD=32'h4000_0008, C_BE=7, burst of 3 words
//    (11111111, 22222222, 33333333), BE=0 -> mem[2..4] hold data; devsel=0 one clk
//    after addr; BACKOFF drives devsel=trdy=1 for one cycle, then Z.
//  2 Read back: AD=32'h4000_0008, C_BE=6, 3 phases -> TURN cycle with AD=Z, then AD
//    returns 11111111, 22222222, 33333333.
//  3 Byte enables: write 32'hAABBCCDD with C_BE=4'b1010 into a word holding 0 ->
//    word reads 32'h00BB00DD.
//  4 Wrap and waits: start index 7, burst of 2 with irdy high for 2 clocks
//    mid-burst -> data lands at 7 then 0; ptr and AD held during the stall.
//  5 Miss: AD[31:30]=2, or C_BE=4'b0010 -> devsel, trdy and AD stay Z; busy=0.
//  6 rst_n low in DATA mid-write burst -> outputs Z next instant; state IDLE; mem=0;
//    next transaction decodes normally. Repeat with WAIT_STATES=2: trdy is delayed
//    by 2 clks.

Source files
------------

// File: rtl/pci_target_controller.sv
// PCI memory target: claims read/write bursts addressed to DEV_ID, holds a
// small word memory, returns read data on AD and merges write data by byte.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | not claimed; devsel, trdy and AD released
// TURN    | read claimed; one cycle of AD turnaround before driving it
// WAIT    | claimed; counting down wait states before the first trdy
// DATA    | trdy asserted; one word moves on each cycle with irdy low
// BACKOFF | last word moved; devsel/trdy driven high for one cycle
module pci_target_controller #(
    parameter logic [1:0] DEV_ID      = 2'b01,
    parameter int         MEM_DEPTH   = 8,
    parameter int         WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame,
    input  logic        irdy,
    input  logic [3:0]  C_BE,
    inout  wire  [31:0] AD,
    output logic        devsel,
    output logic        trdy,
    output logic        busy
);

    localparam int         AW = $clog2(MEM_DEPTH);
    localparam logic [1:0] WS = 2'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, TURN, WAIT, DATA, BACKOFF} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            frame_q;
    logic [AW-1:0]   ptr;
    logic            cmd_wr;
    logic [1:0]      wcnt;
    logic [31:0]     mem [MEM_DEPTH];

    logic            addr_hit;
    logic            xfer;
    logic            bus_en;
    logic            devsel_val;
    logic            trdy_val;
    logic            ad_en;

    // Address phase is the falling edge of frame; claim only our device and
    // the memory read/write commands.
    assign addr_hit = !frame && frame_q && (AD[31:30] == DEV_ID)
                      && ((C_BE == 4'b0110) || (C_BE == 4'b0111));
    assign xfer     = (state == DATA) && !irdy;
    assign busy     = (state != IDLE);

    assign devsel = bus_en ? devsel_val : 1'bz;
    assign trdy   = bus_en ? trdy_val   : 1'bz;
    assign AD     = ad_en  ? mem[ptr]   : 32'bz;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and bus drive values; wait-state count ends on the cycle
    // whose decrement reaches zero so WAIT lasts exactly WAIT_STATES cycles.
    always_comb begin
        state_nxt  = state;
        bus_en     = 1'b0;
        devsel_val = 1'b1;
        trdy_val   = 1'b1;
        ad_en      = 1'b0;
        case (state)
            IDLE: begin
                if (addr_hit) begin
                    if (!C_BE[0])          state_nxt = TURN;
                    else if (WS == 2'd0)   state_nxt = DATA;
                    else                   state_nxt = WAIT;
                end
            end
            TURN: begin
                bus_en     = 1'b1;
                devsel_val = 1'b0;
                state_nxt  = (WS == 2'd0) ? DATA : WAIT;
            end
            WAIT: begin
                bus_en     = 1'b1;
                devsel_val = 1'b0;
                if (wcnt <= 2'd1) state_nxt = DATA;
            end
            DATA: begin
                bus_en     = 1'b1;
                devsel_val = 1'b0;
                trdy_val   = 1'b0;
                ad_en      = !cmd_wr;
                if (!irdy && frame) state_nxt = BACKOFF;
            end
            BACKOFF: begin
                bus_en    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction context: start pointer and command latched on the claim,
    // pointer advances (wrapping) on every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 1'b1;
            ptr     <= '0;
            cmd_wr  <= 1'b0;
            wcnt    <= 2'd0;
        end else begin
            frame_q <= frame;
            if (state == IDLE && addr_hit) begin
                ptr    <= AD[AW+1:2];
                cmd_wr <= C_BE[0];
                wcnt   <= WS;
            end else if (state == WAIT) begin
                wcnt <= wcnt - 2'd1;
            end else if (xfer) begin
                ptr <= ptr + AW'(1);
            end
        end
    end

    // Local memory; write transfers update only the enabled byte lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (xfer && cmd_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (!C_BE[i]) mem[ptr][8*i +: 8] <= AD[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_pci_target_controller.sv
// Bench for pci_target_controller: two targets share one bus (device 1 with
// no wait states, device 2 with two), driven by a simple initiator model.
module tb_pci_target_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame;
    logic        irdy;
    logic [3:0]  C_BE;
    logic        ad_oe;
    logic [31:0] ad_drv;
    tri1  [31:0] AD;
    tri1         devsel;
    tri1         trdy;
    logic        busy0;
    logic        busy1;

    assign AD = ad_oe ? ad_drv : 32'bz;

    always #5 clk = ~clk;

    pci_target_controller #(.DEV_ID(2'b01), .MEM_DEPTH(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame(frame), .irdy(irdy), .C_BE(C_BE),
        .AD(AD), .devsel(devsel), .trdy(trdy), .busy(busy0));

    pci_target_controller #(.DEV_ID(2'b10), .MEM_DEPTH(8), .WAIT_STATES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame(frame), .irdy(irdy), .C_BE(C_BE),
        .AD(AD), .devsel(devsel), .trdy(trdy), .busy(busy1));

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic        cur_rd;
    logic [31:0] wdat [8];
    logic [31:0] model_mem [2][8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (!be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 8; w++) model_mem[d][w] = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every read transfer seen on the bus consumes one expected word.
    always @(negedge clk) begin
        if (rst_n && cur_rd && devsel === 1'b0 && trdy === 1'b0 && irdy === 1'b0) begin
            if (exp_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
            else                   chk("rd_data", AD, exp_q.pop_front());
        end
    end

    // One initiator transaction. stall_at: transfer count after which irdy is
    // held high for stall_len cycles. rst_at: transfer count after which reset
    // is pulsed mid-burst (-1 = never).
    task automatic burst(input logic [3:0] cmd, input logic [1:0] dev, input int idx,
                         input int n, input logic [3:0] be, input int stall_at,
                         input int stall_len, input int rst_at);
        bit   wr, hit, seen, xfer;
        int   inst, ws, k, cyc, st_done, wi;
        logic b_me, b_other;
        wr   = (cmd == 4'b0111);
        hit  = (dev == 2'd1 || dev == 2'd2) && (cmd == 4'b0110 || cmd == 4'b0111);
        inst = (dev == 2'd2) ? 1 : 0;
        ws   = (inst == 1) ? 2 : 0;

        if (hit && !wr)
            for (int j = 0; j < n; j++) exp_q.push_back(model_mem[inst][(idx + j) % 8]);

        frame  = 1'b0;
        irdy   = 1'b1;
        C_BE   = cmd;
        ad_oe  = 1'b1;
        ad_drv = {dev, 25'($urandom), 3'(idx), 2'b00};
        tick();

        if (!hit) begin
            frame = 1'b1;
            irdy  = 1'b0;
            C_BE  = be;
            ad_oe = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("miss_busy0", 32'(busy0), 32'd0);
                chk("miss_busy1", 32'(busy1), 32'd0);
                chk("miss_devsel", 32'(devsel), 32'd1);
                chk("miss_trdy", 32'(trdy), 32'd1);
                chk("miss_ad", AD, 32'hFFFF_FFFF);
                tick();
            end
            irdy = 1'b1;
            return;
        end

        cur_rd  = !wr;
        C_BE    = wr ? be : 4'h0;
        irdy    = 1'b0;
        frame   = (n == 1);
        ad_oe   = wr;
        ad_drv  = wdat[0];
        k       = 0;
        cyc     = 0;
        st_done = 0;
        seen    = 0;
        while (k < n && cyc < 64) begin
            @(negedge clk);
            b_me    = inst ? busy1 : busy0;
            b_other = inst ? busy0 : busy1;
            chk("busy_active", 32'(b_me), 32'd1);
            chk("other_idle", 32'(b_other), 32'd0);
            if (cyc == 0) begin
                chk("claim_devsel", 32'(devsel), 32'd0);
                if (!wr) chk("turn_ad", AD, 32'hFFFF_FFFF);
            end
            if (!seen && trdy === 1'b0) begin
                seen = 1;
                chk("latency", 32'(cyc + 1), wr ? 32'(ws + 1) : 32'(ws + 2));
            end
            if (!wr && trdy === 1'b0 && irdy === 1'b1)
                chk("stall_ad", AD, model_mem[inst][(idx + k) % 8]);
            xfer = (trdy === 1'b0) && (irdy === 1'b0);
            tick();
            cyc++;
            if (xfer) begin
                if (wr) begin
                    wi = (idx + k) % 8;
                    model_mem[inst][wi] = merge(model_mem[inst][wi], wdat[k], be);
                end
                k++;
            end
            if (rst_at >= 0 && k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_devsel", 32'(devsel), 32'd1);
                chk("rst_trdy", 32'(trdy), 32'd1);
                chk("rst_busy", 32'(inst ? busy1 : busy0), 32'd0);
                ad_oe  = 1'b0;
                frame  = 1'b1;
                irdy   = 1'b1;
                cur_rd = 1'b0;
                clear_model();
                #1;
                chk("rst_ad", AD, 32'hFFFF_FFFF);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                return;
            end
            if (k < n && k == stall_at && st_done < stall_len) begin
                irdy = 1'b1;
                st_done++;
            end else begin
                irdy = 1'b0;
            end
            frame = (k >= n - 1);
            if (k < n) ad_drv = wdat[k];
        end
        if (k < n) chk("burst_timeout", 32'(k), 32'(n));

        frame  = 1'b1;
        irdy   = 1'b1;
        ad_oe  = 1'b0;
        cur_rd = 1'b0;
        @(negedge clk);
        chk("backoff_busy", 32'(inst ? busy1 : busy0), 32'd1);
        chk("backoff_devsel", 32'(devsel), 32'd1);
        chk("backoff_trdy", 32'(trdy), 32'd1);
        chk("backoff_ad", AD, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        chk("idle_busy", 32'(inst ? busy1 : busy0), 32'd0);
        chk("idle_devsel", 32'(devsel), 32'd1);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, sa;
        logic [1:0] dev;
        rst_n  = 1'b0;
        frame  = 1'b1;
        irdy   = 1'b1;
        C_BE   = 4'h0;
        ad_oe  = 1'b0;
        ad_drv = 32'h0;
        cur_rd = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("reset_busy0", 32'(busy0), 32'd0);
        chk("reset_busy1", 32'(busy1), 32'd0);
        chk("reset_devsel", 32'(devsel), 32'd1);
        chk("reset_trdy", 32'(trdy), 32'd1);
        chk("reset_ad", AD, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three-word write then read-back at index 2.
        wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222; wdat[2] = 32'h3333_3333;
        burst(4'b0111, 2'd1, 2, 3, 4'b0000, 99, 0, -1);
        burst(4'b0110, 2'd1, 2, 3, 4'b0000, 99, 0, -1);

        // Partial byte enables into an empty word.
        wdat[0] = 32'hAABB_CCDD;
        burst(4'b0111, 2'd1, 5, 1, 4'b1010, 99, 0, -1);
        burst(4'b0110, 2'd1, 5, 1, 4'b0000, 99, 0, -1);

        // Wrap from index 7 to 0 with a two-cycle initiator stall.
        wdat[0] = 32'h4444_4444; wdat[1] = 32'h5555_5555;
        burst(4'b0111, 2'd1, 7, 2, 4'b0000, 1, 2, -1);
        burst(4'b0110, 2'd1, 7, 2, 4'b0000, 1, 2, -1);
        burst(4'b0110, 2'd1, 0, 8, 4'b0000, 99, 0, -1);

        // Misses: unknown device, non-memory command.
        burst(4'b0110, 2'd3, 1, 1, 4'b0000, 99, 0, -1);
        burst(4'b0010, 2'd1, 1, 1, 4'b0000, 99, 0, -1);
        burst(4'b0010, 2'd2, 1, 1, 4'b0000, 99, 0, -1);

        // Reset in the middle of a write burst, then memory must read back zero.
        for (int i = 0; i < 8; i++) wdat[i] = $urandom;
        burst(4'b0111, 2'd1, 0, 4, 4'b0000, 99, 0, 2);
        burst(4'b0110, 2'd1, 0, 8, 4'b0000, 99, 0, -1);

        // Wait-state target.
        for (int i = 0; i < 8; i++) wdat[i] = $urandom;
        burst(4'b0111, 2'd2, 6, 3, 4'b0000, 99, 0, -1);
        burst(4'b0110, 2'd2, 0, 8, 4'b0000, 99, 0, -1);

        // Random traffic to both targets.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 8; i++) wdat[i] = $urandom;
            dev = 2'($urandom_range(1, 2));
            n   = $urandom_range(1, 5);
            sa  = (n > 1) ? $urandom_range(1, n - 1) : 99;
            if ($urandom_range(0, 1) == 1)
                burst(4'b0111, dev, $urandom_range(0, 7), n,
                      ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                      sa, $urandom_range(0, 2), -1);
            else
                burst(4'b0110, dev, $urandom_range(0, 7), n, 4'b0000,
                      sa, $urandom_range(0, 2), -1);
        end
        burst(4'b0110, 2'd1, 0, 8, 4'b0000, 99, 0, -1);
        burst(4'b0110, 2'd2, 0, 8, 4'b0000, 99, 0, -1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
